// File: rtl/ad7989_pack_pkg.sv
// ----------------------------------------------------------------------------
// ad7989_pack_pkg
// Shared definitions for the AD7989 AXI4-Stream packer:
//   - state_t   : packer FSM encoding (IDLE / RUN / FLUSH)
//   - SAMPLE_W  : converter sample width (18)
//   - AXIS_W    : stream word width (32)
//   - OVF_CNT_W : dropped-sample counter width (16)
//   - FIFO_W    : FIFO entry width, {tlast, tdata}
// Optional feature macro: AD7989_PACK_SEQ_TAG_EN (frame sequence tag in tdata).
// ----------------------------------------------------------------------------
package ad7989_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int SAMPLE_W  = 18;
    localparam int AXIS_W    = 32;
    localparam int OVF_CNT_W = 16;
    localparam int FIFO_W    = AXIS_W + 1;

    // Places a sample (or zero pad) into a stream word. The 8-bit tag field
    // sits in the top byte; it is simply zero when tagging is compiled out.
    function automatic logic [AXIS_W-1:0] pack_word(
        input logic [7:0]          tag,
        input logic [SAMPLE_W-1:0] sample
    );
        return {tag, 6'b0, sample};
    endfunction

endpackage

// File: rtl/ad7989_sync_fifo.sv
// ----------------------------------------------------------------------------
// ad7989_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever empty is low; rd_en consumes it.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (empties the FIFO)
//   wr_en    in   push request (ignored when full)
//   wr_data  in   WIDTH-bit entry to push
//   rd_en    in   pop request (ignored when empty)
//   rd_data  out  head entry
//   full     out  2**AW entries stored
//   empty    out  no entries stored
// ----------------------------------------------------------------------------
module ad7989_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             push;
    logic             pop;

    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Full and empty both come from the registered count, so a push while
    // full is refused even when a pop happens in the same cycle.
    always_comb begin
        push     = wr_en && !full;
        pop      = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ad7989_axis_packer.sv
// ----------------------------------------------------------------------------
// ad7989_axis_packer
// Buffers 18-bit AD7989 samples in a FIFO and streams them to the AXI DMA as
// fixed-length frames of 32-bit words, tlast on the final word of each frame.
// When capture stops mid-frame the frame is completed with zero words.
// Samples arriving while the FIFO is full are dropped and counted.
// Parameters:
//   FRAME_LEN  words per frame (2..65535)
//   FIFO_AW    FIFO address width, depth 2**FIFO_AW
// Ports:
//   ad_clk         in   sole clock
//   rst_n          in   synchronous active-low reset
//   ad_start       in   capture enable (level; capture begins on rising edge)
//   ad_data        in   18-bit sample
//   ad_data_rdy    in   one-cycle strobe qualifying ad_data
//   m_axis_tdata   out  stream data
//   m_axis_tvalid  out  stream valid
//   m_axis_tready  in   stream ready
//   m_axis_tlast   out  last word of frame
//   busy           out  FSM not idle
//   overflow       out  sticky: a sample was dropped since the last start
//   overflow_cnt   out  dropped-sample count, saturating
// Optional feature macro: AD7989_PACK_SEQ_TAG_EN
//   defined   : tdata = {frame_seq[7:0], 6'b0, sample[17:0]}
//   undefined : tdata = {14'b0, sample[17:0]}
// ----------------------------------------------------------------------------
module ad7989_axis_packer
    import ad7989_pack_pkg::*;
#(
    parameter int FRAME_LEN = 1024,
    parameter int FIFO_AW   = 6
) (
    input  logic                 ad_clk,
    input  logic                 rst_n,
    input  logic                 ad_start,
    input  logic [17:0]          ad_data,
    input  logic                 ad_data_rdy,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy,
    output logic                 overflow,
    output logic [15:0]          overflow_cnt
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_t                 state_q, state_d;
    logic [15:0]            index_q, index_d;
    logic                   start_q, start_d;
    logic                   ovf_q,   ovf_d;
    logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic [7:0]             tag;

    logic                   fifo_wr;
    logic                   wr_last;
    logic [SAMPLE_W-1:0]    wr_sample;
    logic [FIFO_W-1:0]      fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;

`ifdef AD7989_PACK_SEQ_TAG_EN
    logic [7:0]             seq_q, seq_d;
    assign tag = seq_q;
`else
    assign tag = 8'h00;
`endif

    ad7989_sync_fifo #(
        .WIDTH (FIFO_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (ad_clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data ({wr_last, pack_word(tag, wr_sample)}),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Data and last are forced low while nothing is queued so the bus shows
    // zeros after reset instead of stale FIFO storage.
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0   : fifo_rd_data[AXIS_W-1:0];
    assign m_axis_tlast  = fifo_empty ? 1'b0 : fifo_rd_data[AXIS_W];
    assign busy          = (state_q != ST_IDLE);
    assign overflow      = ovf_q;
    assign overflow_cnt  = ovf_cnt_q;

    // Next-state and write control. The RUN exit looks at the index after
    // this cycle's write, so a sample that completes a frame in the same
    // cycle that ad_start falls leads straight to IDLE without padding.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        start_d   = ad_start;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        fifo_wr   = 1'b0;
        wr_last   = 1'b0;
        wr_sample = '0;
`ifdef AD7989_PACK_SEQ_TAG_EN
        seq_d     = seq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ad_start && !start_q) begin
                    state_d   = ST_RUN;
                    index_d   = '0;
                    ovf_d     = 1'b0;
                    ovf_cnt_d = '0;
`ifdef AD7989_PACK_SEQ_TAG_EN
                    seq_d     = '0;
`endif
                end
            end
            ST_RUN: begin
                if (ad_data_rdy) begin
                    if (!fifo_full) begin
                        fifo_wr   = 1'b1;
                        wr_sample = ad_data;
                        wr_last   = (index_q == LAST_IDX);
                        index_d   = wr_last ? '0 : index_q + 16'd1;
`ifdef AD7989_PACK_SEQ_TAG_EN
                        if (wr_last) begin
                            seq_d = seq_q + 8'd1;
                        end
`endif
                    end else begin
                        ovf_d = 1'b1;
                        if (ovf_cnt_q != '1) begin
                            ovf_cnt_d = ovf_cnt_q + 1'b1;
                        end
                    end
                end
                if (!ad_start) begin
                    state_d = (index_d == '0) ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Padding stalls on a full FIFO rather than being dropped.
                if (!fifo_full) begin
                    fifo_wr = 1'b1;
                    wr_last = (index_q == LAST_IDX);
                    index_d = wr_last ? '0 : index_q + 16'd1;
                    if (wr_last) begin
                        state_d = ST_IDLE;
`ifdef AD7989_PACK_SEQ_TAG_EN
                        seq_d   = seq_q + 8'd1;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            start_q   <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
`ifdef AD7989_PACK_SEQ_TAG_EN
            seq_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            start_q   <= start_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
`ifdef AD7989_PACK_SEQ_TAG_EN
            seq_q     <= seq_d;
`endif
        end
    end

endmodule
